// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single-port data BRAM between the CPU mem/wb stage and the neural
// network accelerator's memory requester. At most one access is issued per
// cycle. The CPU has priority, but the accelerator is never starved for more
// than STARVE_LIMIT consecutive cycles. The accelerator can lock the port for
// a burst of up to MAX_BURST beats. Read data is routed back to whichever
// requester issued the read, one cycle after the grant.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   cpu_ren/cpu_wren          CPU load/store request (both high = store)
//   cpu_addr/cpu_wdata        CPU address / store data
//   cpu_gnt, cpu_stall        CPU access issued / CPU request held off
//   cpu_rdata, cpu_rvalid     CPU load data and its valid
//   acc_req/acc_we/acc_lock   accelerator request, write select, burst continue
//   acc_addr/acc_wdata        accelerator address / write data
//   acc_gnt                   accelerator beat issued
//   acc_rdata, acc_rvalid     accelerator read data and its valid
//   mem_en/mem_we             BRAM enable / write enable
//   mem_addr/mem_wdata        BRAM address / write data
//   mem_rdata                 BRAM read data, one cycle after the read
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int STARVE_LIMIT = 4,
    parameter int MAX_BURST    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_ren,
    input  logic              cpu_wren,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              acc_req,
    input  logic              acc_we,
    input  logic              acc_lock,
    input  logic [ADDR_W-1:0] acc_addr,
    input  logic [DATA_W-1:0] acc_wdata,
    output logic              acc_gnt,
    output logic [DATA_W-1:0] acc_rdata,
    output logic              acc_rvalid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int SC_W = $clog2(STARVE_LIMIT + 1);
    localparam int BC_W = $clog2(MAX_BURST + 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t            state_reg;
    logic [SC_W-1:0]   starve_cnt_reg;
    logic [BC_W-1:0]   beat_cnt_reg;
    logic [1:0]        rd_owner_reg;     // {cpu read, acc read} issued last cycle
    logic [DATA_W-1:0] cpu_rdata_reg;
    logic [DATA_W-1:0] acc_rdata_reg;

    logic cpu_req;
    logic starved;
    logic beat_last;

    assign cpu_req   = cpu_ren | cpu_wren;
    assign starved   = (starve_cnt_reg >= SC_W'(STARVE_LIMIT));
    // A granted beat while the counter sits here brings the burst to MAX_BURST.
    assign beat_last = (beat_cnt_reg == BC_W'(MAX_BURST - 1));

    // Grant decision: combinational so an uncontested CPU access costs nothing.
    always_comb begin
        cpu_gnt = 1'b0;
        acc_gnt = 1'b0;
        if (state_reg == ST_BURST) begin
            // Locked: CPU is shut out even during accelerator bubbles.
            acc_gnt = acc_req;
        end else begin
            acc_gnt = acc_req & (~cpu_req | starved);
            cpu_gnt = cpu_req & ~acc_gnt;
        end
    end

    assign cpu_stall = cpu_req & ~cpu_gnt;

    // BRAM port mux; everything is zero when nobody is granted.
    always_comb begin
        mem_en    = cpu_gnt | acc_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_we    = cpu_wren;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (acc_gnt) begin
            mem_we    = acc_we;
            mem_addr  = acc_addr;
            mem_wdata = acc_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            starve_cnt_reg <= '0;
            beat_cnt_reg   <= '0;
            rd_owner_reg   <= '0;
            cpu_rdata_reg  <= '0;
            acc_rdata_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (acc_gnt && acc_lock) begin
                        state_reg    <= ST_BURST;
                        beat_cnt_reg <= BC_W'(1);
                    end
                end
                ST_BURST: begin
                    if (acc_gnt) begin
                        if (!acc_lock || beat_last) begin
                            state_reg    <= ST_IDLE;
                            beat_cnt_reg <= '0;
                        end else begin
                            beat_cnt_reg <= beat_cnt_reg + BC_W'(1);
                        end
                    end
                end
                default: begin
                    state_reg    <= ST_IDLE;
                    beat_cnt_reg <= '0;
                end
            endcase

            // Every accelerator grant clears the counter, which is what makes
            // the CPU win the first cycle after a forced burst release.
            if (acc_req && !acc_gnt) begin
                if (!starved) begin
                    starve_cnt_reg <= starve_cnt_reg + SC_W'(1);
                end
            end else begin
                starve_cnt_reg <= '0;
            end

            rd_owner_reg <= {cpu_gnt & ~cpu_wren, acc_gnt & ~acc_we};

            // Hold copies so rdata keeps its last value when rvalid is low.
            if (rd_owner_reg[1]) begin
                cpu_rdata_reg <= mem_rdata;
            end
            if (rd_owner_reg[0]) begin
                acc_rdata_reg <= mem_rdata;
            end
        end
    end

    assign cpu_rvalid = rd_owner_reg[1];
    assign acc_rvalid = rd_owner_reg[0];
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_reg;
    assign acc_rdata  = acc_rvalid ? mem_rdata : acc_rdata_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Directed bench for dmem_arbiter with STARVE_LIMIT=4 and MAX_BURST=16.
// Inputs change on the falling edge; outputs are sampled 1 ns later, well
// away from the rising edge. mem_rdata is driven directly by the bench as the
// value the BRAM returns for the read issued in the previous cycle.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_ren, cpu_wren;
    logic [15:0] cpu_addr, cpu_wdata;
    logic        cpu_gnt, cpu_stall, cpu_rvalid;
    logic [15:0] cpu_rdata;
    logic        acc_req, acc_we, acc_lock;
    logic [15:0] acc_addr, acc_wdata;
    logic        acc_gnt, acc_rvalid;
    logic [15:0] acc_rdata;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .ADDR_W(16), .DATA_W(16), .STARVE_LIMIT(4), .MAX_BURST(16)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_ren(cpu_ren), .cpu_wren(cpu_wren),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall),
        .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .acc_req(acc_req), .acc_we(acc_we), .acc_lock(acc_lock),
        .acc_addr(acc_addr), .acc_wdata(acc_wdata),
        .acc_gnt(acc_gnt), .acc_rdata(acc_rdata), .acc_rvalid(acc_rvalid),
        .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic grants(input string tag, input logic cg, input logic ag,
                          input logic st);
        chk({tag, ".cpu_gnt"}, 32'(cpu_gnt), 32'(cg));
        chk({tag, ".acc_gnt"}, 32'(acc_gnt), 32'(ag));
        chk({tag, ".cpu_stall"}, 32'(cpu_stall), 32'(st));
        $display("%0t %s: cpu_gnt=%0b acc_gnt=%0b stall=%0b mem_en=%0b addr=%h",
                 $time, tag, cpu_gnt, acc_gnt, cpu_stall, mem_en, mem_addr);
    endtask

    task automatic idle_inputs();
        cpu_ren = 0; cpu_wren = 0; cpu_addr = 0; cpu_wdata = 0;
        acc_req = 0; acc_we = 0; acc_lock = 0; acc_addr = 0; acc_wdata = 0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        mem_rdata = 16'h0;
        repeat (3) @(negedge clk);

        // ---------------- reset state ----------------
        rst = 1'b0;
        #1;
        grants("reset", 0, 0, 0);
        chk("reset.mem_en", 32'(mem_en), 0);
        chk("reset.mem_addr", 32'(mem_addr), 0);
        chk("reset.cpu_rvalid", 32'(cpu_rvalid), 0);
        chk("reset.acc_rvalid", 32'(acc_rvalid), 0);
        chk("reset.cpu_rdata", 32'(cpu_rdata), 0);
        chk("reset.acc_rdata", 32'(acc_rdata), 0);

        // ---------------- CPU only load ----------------
        @(negedge clk);
        cpu_ren = 1; cpu_addr = 16'h0010;
        #1;
        grants("cpu_load", 1, 0, 0);
        chk("cpu_load.mem_en", 32'(mem_en), 1);
        chk("cpu_load.mem_we", 32'(mem_we), 0);
        chk("cpu_load.mem_addr", 32'(mem_addr), 32'h0010);
        @(negedge clk);
        cpu_ren = 0; mem_rdata = 16'hBEEF;
        #1;
        chk("cpu_load.rvalid", 32'(cpu_rvalid), 1);
        chk("cpu_load.rdata", 32'(cpu_rdata), 32'hBEEF);
        chk("cpu_load.acc_rvalid", 32'(acc_rvalid), 0);
        @(negedge clk);
        mem_rdata = 16'h1234;
        #1;
        chk("cpu_hold.rvalid", 32'(cpu_rvalid), 0);
        chk("cpu_hold.rdata", 32'(cpu_rdata), 32'hBEEF);

        // ---------------- CPU store (ren and wren both high) ----------------
        @(negedge clk);
        cpu_ren = 1; cpu_wren = 1; cpu_addr = 16'h0020; cpu_wdata = 16'h5555;
        #1;
        grants("cpu_store", 1, 0, 0);
        chk("cpu_store.mem_we", 32'(mem_we), 1);
        chk("cpu_store.mem_wdata", 32'(mem_wdata), 32'h5555);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("cpu_store.no_rvalid", 32'(cpu_rvalid), 0);

        // ---------------- continuous contention ----------------
        // Starve count starts at 0: CPU wins 4 cycles, accelerator the 5th.
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            cpu_ren = 1; cpu_addr = 16'h0040;
            acc_req = 1; acc_addr = 16'h0300;
            #1;
            if (k % 5 == 0) grants($sformatf("contend%0d", k), 0, 1, 1);
            else            grants($sformatf("contend%0d", k), 1, 0, 0);
        end
        @(negedge clk);
        idle_inputs(); mem_rdata = 16'hA5A5;
        #1;
        chk("contend.acc_rvalid", 32'(acc_rvalid), 1);
        chk("contend.acc_rdata", 32'(acc_rdata), 32'hA5A5);
        chk("contend.cpu_rvalid", 32'(cpu_rvalid), 0);

        // ---------------- locked burst, 4 beats ----------------
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            acc_req = 1; acc_lock = (b < 3); acc_addr = 16'h0100 + 16'(b);
            cpu_ren = (b > 0); cpu_addr = 16'h0050;
            mem_rdata = 16'hD000 + 16'(b);
            #1;
            grants($sformatf("burst%0d", b), 0, 1, (b > 0));
            chk($sformatf("burst%0d.mem_addr", b), 32'(mem_addr), 32'h0100 + b);
            chk($sformatf("burst%0d.acc_rvalid", b), 32'(acc_rvalid), 32'(b > 0));
            if (b > 0) chk($sformatf("burst%0d.acc_rdata", b), 32'(acc_rdata),
                           32'hD000 + b);
        end
        @(negedge clk);
        acc_req = 1; acc_lock = 0; cpu_ren = 1; mem_rdata = 16'hD004;
        #1;
        grants("burst_end", 1, 0, 0);
        chk("burst_end.acc_rvalid", 32'(acc_rvalid), 1);
        chk("burst_end.acc_rdata", 32'(acc_rdata), 32'hD004);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("burst_end.cpu_rvalid", 32'(cpu_rvalid), 1);
        chk("burst_end.acc_rvalid_off", 32'(acc_rvalid), 0);

        // ---------------- forced release at 16 beats ----------------
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            acc_req = 1; acc_lock = 1; acc_addr = 16'h0400 + 16'(k);
            cpu_ren = (k >= 2);
            #1;
            grants($sformatf("force%0d", k), 0, 1, (k >= 2));
        end
        // starve_cnt restarts at 0: CPU wins 4 cycles, then the accelerator.
        for (int k = 17; k <= 21; k++) begin
            @(negedge clk);
            #1;
            if (k == 21) grants($sformatf("force%0d", k), 0, 1, 1);
            else         grants($sformatf("force%0d", k), 1, 0, 0);
        end
        // The beat at 21 locked again: an accelerator bubble keeps the CPU out.
        @(negedge clk);
        acc_req = 0;
        #1;
        grants("bubble", 0, 0, 1);
        chk("bubble.mem_en", 32'(mem_en), 0);
        @(negedge clk);
        acc_req = 1; acc_lock = 0;
        #1;
        grants("bubble_release", 0, 1, 1);
        @(negedge clk);
        acc_req = 0;
        #1;
        grants("after_release", 1, 0, 0);
        @(negedge clk);
        idle_inputs();

        // ---------------- read-owner routing ----------------
        @(negedge clk);
        cpu_ren = 1; cpu_addr = 16'h0030;
        #1;
        grants("route_cpu", 1, 0, 0);
        @(negedge clk);
        cpu_ren = 0; acc_req = 1; acc_addr = 16'h0200; mem_rdata = 16'h1111;
        #1;
        grants("route_acc", 0, 1, 0);
        chk("route_n1.cpu_rvalid", 32'(cpu_rvalid), 1);
        chk("route_n1.cpu_rdata", 32'(cpu_rdata), 32'h1111);
        chk("route_n1.acc_rvalid", 32'(acc_rvalid), 0);
        @(negedge clk);
        acc_req = 0; mem_rdata = 16'h2222;
        #1;
        chk("route_n2.acc_rvalid", 32'(acc_rvalid), 1);
        chk("route_n2.acc_rdata", 32'(acc_rdata), 32'h2222);
        chk("route_n2.cpu_rvalid", 32'(cpu_rvalid), 0);
        chk("route_n2.cpu_rdata", 32'(cpu_rdata), 32'h1111);
        @(negedge clk);
        mem_rdata = 16'h3333;
        acc_req = 1; acc_we = 1; acc_addr = 16'h0044; acc_wdata = 16'h7777;
        #1;
        grants("acc_write", 0, 1, 0);
        chk("acc_write.mem_we", 32'(mem_we), 1);
        chk("acc_write.mem_addr", 32'(mem_addr), 32'h0044);
        chk("acc_write.mem_wdata", 32'(mem_wdata), 32'h7777);
        chk("acc_write.acc_rdata_hold", 32'(acc_rdata), 32'h2222);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("acc_write.no_rvalid", 32'(acc_rvalid), 0);

        // ---------------- reset mid-burst ----------------
        @(negedge clk);
        acc_req = 1; acc_lock = 1; acc_addr = 16'h0500;
        #1;
        grants("rstb1", 0, 1, 0);
        @(negedge clk);
        cpu_ren = 1; acc_addr = 16'h0501;
        #1;
        grants("rstb2", 0, 1, 1);
        @(negedge clk);
        acc_addr = 16'h0502; rst = 1;
        @(negedge clk);
        rst = 0; mem_rdata = 16'h4444;
        #1;
        grants("after_rst", 1, 0, 0);
        chk("after_rst.cpu_rvalid", 32'(cpu_rvalid), 0);
        chk("after_rst.acc_rvalid", 32'(acc_rvalid), 0);
        chk("after_rst.acc_rdata", 32'(acc_rdata), 0);

        @(negedge clk);
        idle_inputs();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
